// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST initiator for the mem_int bus: WR0/RD0 with P(a), WR1/RD1 with ~P(a).
// Optional build macro MEM_BIST_STOP_ON_FAIL_EN ends the test at the first read mismatch.
module mem_bist_ctrl #(
  parameter int         ADDR_WIDTH = 5,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR0  = 3'd1;
  localparam logic [2:0] S_RD0  = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_RD1  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] SEED_W    = DATA_WIDTH'(SEED);

`ifdef MEM_BIST_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) ^ SEED_W;
    return inv ? ~p : p;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH+1:0] err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic                  fail_valid_q, fail_valid_d;
  logic                  cmp_valid_q, cmp_valid_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic                  cmp_inv_q, cmp_inv_d;
  logic                  mismatch_s;
  logic                  in_read_s;

  // Next-state, march sequencing and read-compare bookkeeping.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_addr_d  = fail_addr_q;
    fail_valid_d = fail_valid_q;
    // Read data arrives one cycle after the strobe, so compare info is pipelined by one stage.
    cmp_valid_d  = mem_read_q;
    cmp_addr_d   = mem_addr_q;
    cmp_inv_d    = (state_q == S_RD1);

    in_read_s  = (state_q == S_RD0) || (state_q == S_RD1);
    mismatch_s = cmp_valid_q && in_read_s && (mem_rdata != pattern(cmp_addr_q, cmp_inv_q));

    if (mismatch_s) begin
      err_count_d = err_count_q + (ADDR_WIDTH+2)'(1);
      if (!fail_valid_q) begin
        fail_addr_d  = cmp_addr_q;
        fail_valid_d = 1'b1;
      end else begin
        fail_addr_d  = fail_addr_q;
      end
    end else begin
      err_count_d = err_count_q;
    end

    case (state_q)
      S_IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (start) begin
          state_d      = S_WR0;
          mem_addr_d   = ADDR_ZERO;
          mem_write_d  = 1'b1;
          mem_wdata_d  = pattern(ADDR_ZERO, 1'b0);
          err_count_d  = {(ADDR_WIDTH+2){1'b0}};
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR0, S_WR1: begin
        if (mem_addr_q == ADDR_LAST) begin
          state_d     = (state_q == S_WR0) ? S_RD0 : S_RD1;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = ADDR_ZERO;
        end else begin
          mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
          mem_wdata_d = pattern(mem_addr_q + ADDR_WIDTH'(1), state_q == S_WR1);
        end
      end
      S_RD0, S_RD1: begin
        if (STOP_ON_FAIL && mismatch_s) begin
          state_d     = S_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          done_d      = 1'b1;
          pass_d      = 1'b0;
        end else if (mem_read_q) begin
          if (mem_addr_q == ADDR_LAST) begin
            mem_read_d = 1'b0;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
          end
        end else if (state_q == S_RD0) begin
          state_d     = S_WR1;
          mem_write_d = 1'b1;
          mem_addr_d  = ADDR_ZERO;
          mem_wdata_d = pattern(ADDR_ZERO, 1'b1);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = ~|err_count_d;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and registered outputs; reset drops strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= ADDR_ZERO;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= {(ADDR_WIDTH+2){1'b0}};
      fail_addr_q  <= ADDR_ZERO;
      fail_valid_q <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_addr_q   <= ADDR_ZERO;
      cmp_inv_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_addr_q  <= fail_addr_d;
      fail_valid_q <= fail_valid_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_addr_q   <= cmp_addr_d;
      cmp_inv_q    <= cmp_inv_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_addr  = fail_addr_q;
  assign fail_valid = fail_valid_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a faultable behavioural memory (D=32, SEED=0xA5).
module tb_mem_bist_ctrl;

  localparam int D = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass, fail_valid, mem_read, mem_write;
  logic [6:0] err_count;
  logic [4:0] fail_addr, mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int fault_mode = 0;
  int cyc = 0, done_cnt = 0, viol = 0;
  int rd2_cyc = 0, done_cyc = 0, last_wr_cyc = 0;
  logic [7:0] mem [0:D-1];

  mem_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_valid(fail_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] p_of(input logic [4:0] a);
    return {3'b000, a} ^ 8'hA5;
  endfunction

  function automatic logic [7:0] faulty(input logic [4:0] a, input logic [7:0] d);
    case (fault_mode)
      1:       return (a == 5'd5) ? (d & 8'hF7) : d;
      2:       return (a == 5'd2 || a == 5'd9) ? 8'h00 : d;
      default: return d;
    endcase
  endfunction

  // Behavioural memory: write at the strobed edge, registered read data.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= faulty(mem_addr, mem[mem_addr]);
  end

  // Bus protocol monitor and event timestamps.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    done_cnt <= done_cnt + (done ? 1 : 0);
    viol     <= viol + ((mem_read && mem_write) ? 1 : 0)
                     + ((mem_write && mem_wdata !== p_of(mem_addr) && mem_wdata !== ~p_of(mem_addr)) ? 1 : 0);
    if (mem_read && mem_addr == 5'd2) rd2_cyc <= cyc;
    if (done) done_cyc <= cyc;
    if (mem_write) last_wr_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-length run; start is re-pulsed at relative cycles ka/kb (0 = never).
  task automatic run_test(input string tag, input int ka, input int kb);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 4*D+4; k++) begin
      if (k == 1) begin
        chk({tag, "_busy_first"}, busy, 1);
        chk({tag, "_err_cleared"}, err_count, 0);
        chk({tag, "_fv_cleared"}, fail_valid, 0);
        chk({tag, "_pass_cleared"}, pass, 0);
      end
      if (k == 4*D+2) begin
        chk({tag, "_busy_last"}, busy, 1);
        chk({tag, "_done_early"}, done, 0);
      end
      if (k == 4*D+3) begin
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_busy_in_done"}, busy, 0);
      end
      if (k == 4*D+4) begin
        chk({tag, "_done_after"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
      end
      start = (k == ka || k == kb);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  // Run until done with a cycle bound (early-stop build).
  task automatic run_until_done(input string tag);
    int n;
    n = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!done && n < 4*D+10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_faddr", fail_addr, 0);
    chk("rst_fvalid", fail_valid, 0);
    chk("rst_rd", mem_read, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;

    fault_mode = 0;
    run_test("t1", 0, 0);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_fv", fail_valid, 0);

    fault_mode = 1;
`ifdef MEM_BIST_STOP_ON_FAIL_EN
    run_until_done("t2");
`else
    run_test("t2", 0, 0);
`endif
    chk("t2_err", err_count, 1);
    chk("t2_faddr", fail_addr, 5);
    chk("t2_fv", fail_valid, 1);
    chk("t2_pass", pass, 0);

    fault_mode = 2;
`ifdef MEM_BIST_STOP_ON_FAIL_EN
    run_until_done("t3");
    chk("t3_err", err_count, 1);
    chk("t3_done_lat", done_cyc - rd2_cyc, 2);
    chk("t3_no_wr_after", (last_wr_cyc < rd2_cyc) ? 1 : 0, 1);
`else
    run_test("t3", 0, 0);
    chk("t3_err", err_count, 4);
`endif
    chk("t3_faddr", fail_addr, 2);
    chk("t3_pass", pass, 0);

    fault_mode = 0;
    run_test("t4", 2*D+5, 4*D+3);
    chk("t4_pass", pass, 1);
    chk("t4_err", err_count, 0);
    chk("t4_fv", fail_valid, 0);
    chk("t4_faddr_held", fail_addr, 2);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (D+4) @(posedge clk);
    #1;
    chk("t5_rd_before", mem_read, 1);
    chk("t5_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rd_async", mem_read, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_err_async", err_count, 0);
    chk("t5_addr_async", mem_addr, 0);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt - d0, 0);
    run_test("t6", 0, 0);
    chk("t6_pass", pass, 1);
    chk("t6_err", err_count, 0);

    chk("bus_monitor", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
